// File: rtl/chunk_xfer_ctrl_if.sv
// Bus bundle between chunk_xfer_ctrl and its neighbours: the inbound DDR
// stream, the BRAM write/read port and the outbound DDR stream.
interface chunk_xfer_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] bram_wdata;
    logic [ADDR_W-1:0] DDR_addr;
    logic              wen;
    logic [DATA_W-1:0] bram_rdata;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    // Environment side: inbound words, BRAM read data, outbound backpressure.
    modport master (
        output s_data, s_valid, bram_rdata, m_ready,
        input  s_ready, bram_wdata, DDR_addr, wen, m_data, m_valid
    );

    // Controller side.
    modport slave (
        input  s_data, s_valid, bram_rdata, m_ready,
        output s_ready, bram_wdata, DDR_addr, wen, m_data, m_valid
    );
endinterface

// File: rtl/chunk_xfer_ctrl.sv
// Chunk transfer controller: streams one chunk of DDR words into BRAM, hands
// the BRAM to the LBM engine, then streams the result back out through a
// 2-entry FIFO that absorbs the BRAM's one-cycle read latency.
module chunk_xfer_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int CHUNK_WORDS = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             lbm_done,
    output logic             chunk_transfer_ready,
    output logic             chunk_compute_ready,
    output logic             busy,
    output logic [15:0]      chunks_done,
    chunk_xfer_ctrl_if.slave bus
);
    // One extra bit so the read counter can reach CHUNK_WORDS == 2**ADDR_W.
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHUNK_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHUNK_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;          // write index in LOAD, read index in DRAIN
    logic [CNT_W-1:0]  pop_cnt_q, pop_cnt_d;  // words handed out in DRAIN
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] fifo_q [2];
    logic [DATA_W-1:0] fifo_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic [15:0]       chunks_done_q, chunks_done_d;

    logic              xfer_s;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic [2:0]        pending_s;

    // Next-state, counters, FIFO bookkeeping and all bus outputs.
    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        pop_cnt_d            = pop_cnt_q;
        chunks_done_d        = chunks_done_q;
        wr_ptr_d             = wr_ptr_q;
        rd_ptr_d             = rd_ptr_q;
        occ_d                = occ_q;
        fifo_d[0]            = fifo_q[0];
        fifo_d[1]            = fifo_q[1];
        xfer_s               = 1'b0;
        issue_s              = 1'b0;
        bus.s_ready          = 1'b0;
        bus.wen              = 1'b0;
        bus.bram_wdata       = '0;
        bus.DDR_addr         = '0;
        chunk_transfer_ready = 1'b0;
        chunk_compute_ready  = 1'b0;

        // A read issued last cycle always lands in the FIFO this cycle.
        push_s      = inflight_q;
        bus.m_valid = (state_q == DRAIN) && (occ_q != 2'd0);
        bus.m_data  = fifo_q[rd_ptr_q];
        pop_s       = bus.m_valid && bus.m_ready;
        pending_s   = {1'b0, occ_q} + {2'b00, inflight_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            LOAD: begin
                bus.s_ready          = 1'b1;
                chunk_transfer_ready = 1'b1;
                bus.DDR_addr         = cnt_q[ADDR_W-1:0];
                bus.bram_wdata       = bus.s_data;
                xfer_s               = bus.s_valid;
                bus.wen              = xfer_s;
                if (xfer_s) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            COMPUTE: begin
                chunk_compute_ready = 1'b1;
                if (lbm_done) begin
                    state_d   = DRAIN;
                    cnt_d     = '0;
                    pop_cnt_d = '0;
                end else begin
                    state_d = COMPUTE;
                end
            end

            DRAIN: begin
                chunk_transfer_ready = 1'b1;
                bus.DDR_addr         = cnt_q[ADDR_W-1:0];
                // Never have more words owed to the FIFO than it can hold.
                issue_s = (cnt_q < FULL_CNT) && (pending_s < 3'd2);
                if (issue_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                if (pop_s) begin
                    if (pop_cnt_q == LAST_IDX) begin
                        state_d       = IDLE;
                        cnt_d         = '0;
                        pop_cnt_d     = '0;
                        chunks_done_d = chunks_done_q + 16'd1;
                    end else begin
                        pop_cnt_d = pop_cnt_q + CNT_W'(1);
                    end
                end else begin
                    pop_cnt_d = pop_cnt_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        inflight_d = issue_s;

        if (push_s) begin
            fifo_d[wr_ptr_q] = bus.bram_rdata;
            wr_ptr_d         = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // State, counters and FIFO registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pop_cnt_q     <= '0;
            inflight_q    <= 1'b0;
            fifo_q[0]     <= '0;
            fifo_q[1]     <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            occ_q         <= 2'd0;
            chunks_done_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pop_cnt_q     <= pop_cnt_d;
            inflight_q    <= inflight_d;
            fifo_q[0]     <= fifo_d[0];
            fifo_q[1]     <= fifo_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            chunks_done_q <= chunks_done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign chunks_done = chunks_done_q;

endmodule

// File: tb/tb_chunk_xfer_ctrl.sv
// Randomized scoreboard bench for chunk_xfer_ctrl with a 4-word chunk, a
// behavioural BRAM and an LBM stand-in that may overwrite the chunk.
module tb_chunk_xfer_ctrl;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int CW     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        lbm_done;
    logic        ctr;
    logic        ccr;
    logic        busy;
    logic [15:0] chunks_done;

    chunk_xfer_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    chunk_xfer_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHUNK_WORDS(CW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .lbm_done             (lbm_done),
        .chunk_transfer_ready (ctr),
        .chunk_compute_ready  (ccr),
        .busy                 (busy),
        .chunks_done          (chunks_done),
        .bus                  (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_pop_cyc = 0;
    int          exp_chunks = 0;
    int          mready_mode = 1;      // 0: hold low, 1: random 50%
    int          exp_wa [$];
    logic [31:0] exp_wd [$];
    logic [31:0] exp_out [$];
    logic [31:0] cur [CW];

    logic [31:0] mem [16];
    logic        lbm_we;
    logic [3:0]  lbm_addr;
    logic [31:0] lbm_wdata;

    // Cycle counter for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural BRAM: one write port shared with the LBM, 1-cycle read.
    always @(posedge clk) begin
        if (bus.wen) mem[bus.DDR_addr[3:0]] <= bus.bram_wdata;
        else if (lbm_we) mem[lbm_addr] <= lbm_wdata;
        bus.bram_rdata <= mem[bus.DDR_addr[3:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %0d, expected nothing (cycle %0d)", name, act, cyc);
    endtask

    // Outbound backpressure driver.
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mready_mode == 0) bus.m_ready = 1'b0;
            else bus.m_ready = 1'($urandom_range(0, 1));
        end
    end

    // Write-port monitor: every BRAM write must match the next expected word.
    always @(negedge clk) begin
        if (bus.wen) begin
            if (exp_wa.size() == 0) fail_now("unexpected_write", bus.bram_wdata);
            else begin
                chk("write_addr", 32'(bus.DDR_addr), 32'(exp_wa.pop_front()));
                chk("write_data", bus.bram_wdata, exp_wd.pop_front());
            end
        end
    end

    // Output monitor: every popped word must match the next expected word.
    always @(negedge clk) begin
        if (bus.m_valid && bus.m_ready) begin
            last_pop_cyc <= cyc;
            if (exp_out.size() == 0) fail_now("unexpected_output", bus.m_data);
            else chk("m_data", bus.m_data, exp_out.pop_front());
        end
    end

    // Per-cycle phase invariants.
    always @(negedge clk) begin
        chk("ready_exclusive", 32'(ctr & ccr), 32'd0);
        chk("wen_vs_handshake", 32'(bus.wen), 32'(bus.s_valid & bus.s_ready));
        chk("busy_vs_phase", 32'(busy), 32'(ctr | ccr));
    end

    task automatic chk_reset_vals();
        chk("reset_flags", 32'({bus.s_ready, bus.wen, ctr, ccr, bus.m_valid, busy}), 32'd0);
        chk("reset_addr", 32'(bus.DDR_addr), 32'd0);
        chk("reset_chunks_done", 32'(chunks_done), 32'd0);
    endtask

    // Start (first cycle) and feed n words; vmode 0 always valid, 1 toggle, 2 random.
    task automatic load_words(input int n, input int vmode, input bit hold, input bit noise);
        int k = 0;
        int j = 0;
        int guard = 0;
        bit first = 1'b1;
        bit v;
        while (k < n && guard < 200) begin
            @(posedge clk);
            #1;
            start = first | hold;
            first = 1'b0;
            if (noise) lbm_done = 1'($urandom_range(0, 1));
            if (bus.s_ready) begin
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = (j % 2 == 0);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                j++;
            end else begin
                v = 1'b0;
            end
            bus.s_valid = v;
            bus.s_data  = cur[k];
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) k++;
            guard++;
        end
        if (k < n) fail_now("load_timeout", 32'(k));
        if (n == CW) begin
            @(posedge clk);
            #1;
            bus.s_valid = 1'b0;
            lbm_done    = 1'b0;
            @(negedge clk);
            chk("compute_entry", 32'({ccr, ctr}), 32'd2);
        end
    endtask

    // LBM stand-in: optionally overwrite mem[i]=100+i, then pulse lbm_done.
    task automatic compute_phase(input int ctime, input bit rewrite);
        for (int c = 0; c < ctime; c++) begin
            @(posedge clk);
            #1;
            if (rewrite && c < CW) begin
                lbm_we    = 1'b1;
                lbm_addr  = 4'(c);
                lbm_wdata = 32'(100 + c);
            end else begin
                lbm_we = 1'b0;
            end
            @(negedge clk);
            chk("compute_phase", 32'({ccr, ctr, bus.wen, bus.s_ready, bus.m_valid}), 32'd16);
        end
        @(posedge clk);
        #1;
        lbm_we   = 1'b0;
        lbm_done = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        lbm_done = 1'b0;
        @(negedge clk);
        chk("drain_entry", 32'({ccr, ctr}), 32'd1);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (busy) fail_now("drain_timeout", 32'(g));
        else begin
            chk("idle_after_last_pop", 32'(cyc), 32'(last_pop_cyc + 1));
            chk("all_words_out", 32'(exp_out.size()), 32'd0);
            chk("chunks_done", 32'(chunks_done), 32'(exp_chunks));
        end
    endtask

    task automatic run_chunk(input int vmode, input bit rewrite, input int ctime,
                             input bit stall, input bit noise, input bit hold);
        for (int k = 0; k < CW; k++) begin
            exp_wa.push_back(k);
            exp_wd.push_back(cur[k]);
            exp_out.push_back(rewrite ? 32'(100 + k) : cur[k]);
        end
        if (stall) mready_mode = 0;
        load_words(CW, vmode, hold, noise);
        compute_phase((rewrite && ctime < CW) ? CW : ctime, rewrite);
        if (stall) begin
            for (int i = 1; i < 10; i++) begin
                @(negedge clk);
                if (i >= 3) begin
                    chk("stall_addr", 32'(bus.DDR_addr), 32'd2);
                    chk("stall_valid", 32'(bus.m_valid), 32'd1);
                    chk("stall_data", bus.m_data, exp_out[0]);
                end
            end
            mready_mode = 1;
        end
        exp_chunks = (exp_chunks + 1) % 65536;
        wait_idle();
    endtask

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        lbm_done    = 1'b0;
        lbm_we      = 1'b0;
        lbm_addr    = 4'd0;
        lbm_wdata   = 32'd0;
        bus.s_data  = 32'd0;
        bus.s_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals();

        // Back-to-back load of 10..13, data returned unchanged.
        for (int k = 0; k < CW; k++) cur[k] = 32'(10 + k);
        run_chunk(0, 1'b0, 3, 1'b0, 1'b0, 1'b0);

        // Toggling s_valid, long compute, LBM writes 100+i.
        for (int k = 0; k < CW; k++) cur[k] = $urandom;
        run_chunk(1, 1'b1, 20, 1'b0, 1'b0, 1'b0);

        // Output stalled for the first 10 drain cycles.
        for (int k = 0; k < CW; k++) cur[k] = $urandom;
        run_chunk(0, 1'b1, 4, 1'b1, 1'b0, 1'b0);

        // Random chunks with lbm_done noise during load.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < CW; k++) cur[k] = $urandom;
            run_chunk(2, 1'($urandom_range(0, 1)), 32'($urandom_range(1, 12)), 1'b0, 1'b1, 1'b0);
        end

        // Reset in the middle of LOAD at address 2, then reload from 0.
        for (int k = 0; k < CW; k++) cur[k] = $urandom;
        for (int k = 0; k < 2; k++) begin
            exp_wa.push_back(k);
            exp_wd.push_back(cur[k]);
        end
        load_words(2, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        chk("mid_load_addr", 32'(bus.DDR_addr), 32'd2);
        chk("mid_load_phase", 32'(ctr), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        exp_chunks = 0;
        for (int k = 0; k < CW; k++) cur[k] = $urandom;
        run_chunk(2, 1'b0, 5, 1'b0, 1'b0, 1'b0);

        // start held high through a chunk: ignored while busy, restarts at once.
        for (int k = 0; k < CW; k++) cur[k] = $urandom;
        run_chunk(0, 1'b1, 6, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("restart_on_held_start", 32'({busy, ctr}), 32'd3);
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/chunk_xfer_ctrl.md
CHUNK_XFER_CTRL -- requirements
Module: chunk_xfer_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 12, BRAM word-address width
- DATA_W, 32, BRAM/stream data width
- CHUNK_WORDS, 4096, words per chunk (2..2^ADDR_W)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge
- rst, in, 1, synchronous active-high reset
- start, in, 1, begin one chunk cycle; sampled only in IDLE
- s_data, in, DATA_W, inbound DDR word
- s_valid, in, 1, inbound word valid
- s_ready, out, 1, inbound word accepted
- bram_wdata, out, DATA_W, BRAM write data
- DDR_addr, out, ADDR_W, BRAM address during LOAD/DRAIN
- wen, out, 1, BRAM write enable
- chunk_transfer_ready, out, 1, DDR side owns BRAM address port
- chunk_compute_ready, out, 1, LBM side owns BRAM address port
- lbm_done, in, 1, LBM finished computing the chunk
- bram_rdata, in, DATA_W, BRAM read data, 1-cycle latency
- m_data, out, DATA_W, outbound DDR word
- m_valid, out, 1, outbound word valid
- m_ready, in, 1, outbound word accepted
- busy, out, 1, state != IDLE
- chunks_done, out, 16, completed-chunk counter

Function
REQ-003 FSM states SHALL be IDLE, LOAD, COMPUTE, DRAIN; one-hot or binary encoding is free.
REQ-004 IDLE: start=1 -> LOAD with addr counter=0; else stay.
REQ-005 LOAD: s_ready=1; a word transfers when s_valid&s_ready; on transfer, wen=1, bram_wdata=s_data, DDR_addr=counter, counter+1, all combinational in the same cycle.
REQ-006 LOAD: no transfer -> wen=0, counter holds; the transfer at counter=CHUNK_WORDS-1 -> COMPUTE next cycle, counter cleared.
REQ-007 chunk_transfer_ready SHALL be 1 exactly in LOAD and DRAIN; chunk_compute_ready SHALL be 1 exactly in COMPUTE; the two are never both 1.
REQ-008 COMPUTE: s_ready=0, wen=0, m_valid=0; lbm_done=1 -> DRAIN next cycle; lbm_done is ignored in all other states.
REQ-009 DRAIN: DDR_addr=read counter; a read is issued in a cycle iff counter<CHUNK_WORDS and (FIFO occupancy + reads in flight) < 2; on issue, counter+1.
REQ-010 Read data returns on bram_rdata the cycle after issue and SHALL be pushed into a 2-entry output FIFO; m_data/m_valid are driven by the FIFO head; a pop occurs on m_valid&m_ready.
REQ-011 The FIFO SHALL never overflow; a simultaneous push and pop on a full FIFO is legal; word order is preserved.
REQ-012 DRAIN -> IDLE when all CHUNK_WORDS words have been popped; chunks_done+1 (wraps at 16'hFFFF->0) in that same transition cycle.
REQ-013 start asserted outside IDLE SHALL be ignored; start held high in IDLE after a chunk completes immediately begins the next chunk.
REQ-014 wen SHALL be 0 in every state except LOAD; s_ready SHALL be 0 outside LOAD.

Reset
REQ-015 rst=1 at a clock edge, in any state including mid-LOAD or mid-DRAIN, SHALL force IDLE, clear counters, flush the FIFO and in-flight flag, and zero chunks_done.
REQ-016 Values during and after reset until the first start: s_ready=0, wen=0, chunk_transfer_ready=0, chunk_compute_ready=0, m_valid=0, busy=0, DDR_addr=0, chunks_done=0.

Verification
REQ-017 CHUNK_WORDS=4, start pulse, s_valid held 1 with data 10,11,12,13 -> wen high 4 cycles at addr 0..3, COMPUTE entered next cycle.
REQ-018 LOAD with s_valid toggling 1,0,1,0 -> wen mirrors it, addresses 0,1 with no gaps or repeats.
REQ-019 COMPUTE with lbm_done low for 20 cycles -> chunk_compute_ready=1, chunk_transfer_ready=0, wen=0 throughout; lbm_done pulse -> DRAIN.
REQ-020 DRAIN with BRAM model holding mem[i]=100+i, m_ready random at 50% -> m_data sequence 100,101,102,103 with no loss or duplication; IDLE entered after the last pop; chunks_done=1.
REQ-021 DRAIN with m_ready=0 for 10 cycles -> occupancy saturates at 2, read counter stops at 2, m_data=100 held stable.
REQ-022 rst asserted mid-LOAD at addr 2 -> the next cycle shows IDLE and all REQ-016 values; a following start reloads from addr 0.
